// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: round-robin grant over four sources, one mux-settle cycle, then a single write pulse.
// Build option WB_LOAD_PRIORITY_EN: the load source (1) always wins in IDLE and its wins leave the pointer alone.
module wb_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int NSRC   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NSRC-1:0]        req,
    input  logic [NSRC*ADDR_W-1:0] rd_in,
    output logic [NSRC-1:0]        ack,
    output logic [1:0]             sel,
    output logic                   reg_we,
    output logic [ADDR_W-1:0]      reg_rd,
    output logic                   busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [1:0]        ptr_reg,   ptr_next;
    logic [1:0]        sel_reg,   sel_next;
    logic [ADDR_W-1:0] rd_reg,    rd_next;
    logic              we_reg,    we_next;
    logic [NSRC-1:0]   ack_reg,   ack_next;
    logic              busy_reg,  busy_next;
`ifdef WB_LOAD_PRIORITY_EN
    logic              prio_reg,  prio_next;
    logic              load_win;
`endif

    logic [ADDR_W-1:0] rd_slice [NSRC];
    logic [1:0]        rr_idx   [NSRC];
    logic [1:0]        win;
    logic              rr_found;
    logic              req_any;

    // Per-source rd field and the round-robin search order starting at the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign rd_slice[gi] = rd_in[gi*ADDR_W +: ADDR_W];
            assign rr_idx[gi]   = ptr_reg + 2'(gi);
        end
    endgenerate

    assign req_any = |req;

    always_comb begin
        win      = ptr_reg;
        rr_found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (!rr_found && req[rr_idx[k]]) begin
                win      = rr_idx[k];
                rr_found = 1'b1;
            end
        end
`ifdef WB_LOAD_PRIORITY_EN
        load_win = req[1];
        if (load_win) begin
            win = 2'd1;
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        rd_next    = rd_reg;
        we_next    = 1'b0;
        ack_next   = '0;
        busy_next  = busy_reg;
`ifdef WB_LOAD_PRIORITY_EN
        prio_next  = prio_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                busy_next = 1'b0;
                if (req_any) begin
                    state_next = S_SETUP;
                    sel_next   = win;
                    rd_next    = rd_slice[win];
                    busy_next  = 1'b1;
`ifdef WB_LOAD_PRIORITY_EN
                    prio_next  = load_win;
`endif
                end
            end
            S_SETUP: begin
                // A source that dropped its request during settle is abandoned silently.
                if (!req[sel_reg]) begin
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                end else begin
                    state_next        = S_WRITE;
                    we_next           = (rd_reg != '0);
                    ack_next[sel_reg] = 1'b1;
                end
            end
            S_WRITE: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
`ifdef WB_LOAD_PRIORITY_EN
                if (!prio_reg) begin
                    ptr_next = sel_reg + 2'd1;
                end
`else
                ptr_next = sel_reg + 2'd1;
`endif
            end
            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            ptr_reg   <= 2'd0;
            sel_reg   <= 2'd0;
            rd_reg    <= '0;
            we_reg    <= 1'b0;
            ack_reg   <= '0;
            busy_reg  <= 1'b0;
`ifdef WB_LOAD_PRIORITY_EN
            prio_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
            rd_reg    <= rd_next;
            we_reg    <= we_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
`ifdef WB_LOAD_PRIORITY_EN
            prio_reg  <= prio_next;
`endif
        end
    end

    assign ack    = ack_reg;
    assign sel    = sel_reg;
    assign reg_we = we_reg;
    assign reg_rd = rd_reg;
    assign busy   = busy_reg;

endmodule
